// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the multi-channel debounce controller.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    // Counter widths never drop below one bit, even for degenerate parameters.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tcnt_width(input int tick_max);
        return cnt_width(tick_max);
    endfunction

    function automatic int scnt_width(input int stable_ticks);
        return cnt_width(stable_ticks + 1);
    endfunction

    function automatic int rcnt_width(input int repeat_ticks);
        return cnt_width(repeat_ticks + 1);
    endfunction

    localparam int TCNT_W_DEFAULT = tcnt_width(50000);
    localparam int SCNT_W_DEFAULT = scnt_width(4);
    localparam int RCNT_W_DEFAULT = rcnt_width(25);

endpackage

// File: rtl/debounce_tick_gen.sv
// Free-running sample-tick generator: one registered pulse every TICK_MAX clocks.
module debounce_tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_MAX = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int TW = tcnt_width(TICK_MAX);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_MAX - 1);

    logic [TW-1:0] tcnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_reg <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tcnt_reg == TCNT_LAST);
            tcnt_reg <= (tcnt_reg == TCNT_LAST) ? '0 : tcnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/debounce_ctrl.sv
// N_CH-channel debouncer sharing one sample tick; each channel has a 2-flop sync and confirm FSM.
// Optional auto-repeat pulses are built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_MAX     = 50000,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_TICKS = 25
) (
    input  logic            clk,
    input  logic            rst_a_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_repeat,
    output logic            tick_o
);

    localparam int SW = scnt_width(STABLE_TICKS);
    localparam logic [SW-1:0] SCNT_LAST = SW'(STABLE_TICKS - 1);

    if (N_CH < 1 || TICK_MAX < 2 || STABLE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
        $error("debounce_ctrl: illegal parameter combination");
    end

    logic tick;

    debounce_tick_gen #(
        .TICK_MAX(TICK_MAX)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_a_n),
        .tick (tick)
    );

    assign tick_o = tick;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [1:0]    sync_reg;
        logic          sync;
        state_t        state_reg;
        logic [SW-1:0] scnt_reg;
        logic          level_reg;
        logic          rise_reg;
        logic          fall_reg;

        assign sync = sync_reg[1];

        always_ff @(posedge clk or negedge rst_a_n) begin
            if (!rst_a_n) begin
                sync_reg  <= 2'b00;
                state_reg <= ST_LO;
                scnt_reg  <= '0;
                level_reg <= 1'b0;
                rise_reg  <= 1'b0;
                fall_reg  <= 1'b0;
            end else begin
                sync_reg <= {sync_reg[0], btn_in[gi]};
                rise_reg <= 1'b0;
                fall_reg <= 1'b0;
                if (tick) begin
                    case (state_reg)
                        ST_LO: if (sync) begin
                            if (STABLE_TICKS == 1) begin
                                state_reg <= ST_HI;
                                level_reg <= 1'b1;
                                rise_reg  <= 1'b1;
                            end else begin
                                state_reg <= CHK_HI;
                                scnt_reg  <= SW'(1);
                            end
                        end
                        CHK_HI: if (!sync) begin
                            // A low sample mid-check is a bounce: start over silently.
                            state_reg <= ST_LO;
                            scnt_reg  <= '0;
                        end else if (scnt_reg == SCNT_LAST) begin
                            state_reg <= ST_HI;
                            scnt_reg  <= '0;
                            level_reg <= 1'b1;
                            rise_reg  <= 1'b1;
                        end else begin
                            scnt_reg <= scnt_reg + 1'b1;
                        end
                        ST_HI: if (!sync) begin
                            if (STABLE_TICKS == 1) begin
                                state_reg <= ST_LO;
                                level_reg <= 1'b0;
                                fall_reg  <= 1'b1;
                            end else begin
                                state_reg <= CHK_LO;
                                scnt_reg  <= SW'(1);
                            end
                        end
                        CHK_LO: if (sync) begin
                            state_reg <= ST_HI;
                            scnt_reg  <= '0;
                        end else if (scnt_reg == SCNT_LAST) begin
                            state_reg <= ST_LO;
                            scnt_reg  <= '0;
                            level_reg <= 1'b0;
                            fall_reg  <= 1'b1;
                        end else begin
                            scnt_reg <= scnt_reg + 1'b1;
                        end
                    endcase
                end
            end
        end

        assign btn_level[gi] = level_reg;
        assign btn_rise[gi]  = rise_reg;
        assign btn_fall[gi]  = fall_reg;

`ifdef DEBOUNCE_AUTOREPEAT_EN
        localparam int RW = rcnt_width(REPEAT_TICKS);
        localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_TICKS - 1);

        logic [RW-1:0] rcnt_reg;
        logic          repeat_reg;

        // rcnt is held at zero outside ST_HI, so entering ST_HI always starts a fresh period.
        always_ff @(posedge clk or negedge rst_a_n) begin
            if (!rst_a_n) begin
                rcnt_reg   <= '0;
                repeat_reg <= 1'b0;
            end else begin
                repeat_reg <= 1'b0;
                if (state_reg != ST_HI) begin
                    rcnt_reg <= '0;
                end else if (tick) begin
                    if (!sync) begin
                        rcnt_reg <= '0;
                    end else if (rcnt_reg == RCNT_LAST) begin
                        rcnt_reg   <= '0;
                        repeat_reg <= 1'b1;
                    end else begin
                        rcnt_reg <= rcnt_reg + 1'b1;
                    end
                end
            end
        end

        assign btn_repeat[gi] = repeat_reg;
`else
        assign btn_repeat[gi] = 1'b0;
`endif
    end

endmodule

// File: doc/debounce_ctrl.md
Name: debounce_ctrl

Overview:
Multi-channel debounce controller that schedules one shared sample-tick counter across N_CH noisy inputs, such as buttons or switches.
- Each channel has a 2-flop synchronizer and a 4-state confirm FSM, clocked by the shared tick.
- Outputs are a clean level plus one-cycle rise/fall pulses per channel.
- Sits between board I/O pins and the user-logic control FSMs.

Parameters:
N_CH, 4, number of debounced channels (>=1)
TICK_MAX, 50000, clk cycles per sample tick; tick period = TICK_MAX (>=2)
STABLE_TICKS, 4, consecutive agreeing samples required to change state (>=1)
REPEAT_TICKS, 25, ticks between auto-repeat pulses (used only with DEBOUNCE_AUTOREPEAT_EN)

Ports:
clk  in  1  system clock
rst_a_n  in  1  asynchronous active-low reset
btn_in  in  N_CH  raw asynchronous inputs
btn_level  out  N_CH  debounced level, registered
btn_rise  out  N_CH  1-cycle pulse on debounced 0->1
btn_fall  out  N_CH  1-cycle pulse on debounced 1->0
btn_repeat  out  N_CH  auto-repeat pulse; tied 0 without the macro
tick_o  out  1  shared sample tick, 1-cycle pulse, exported for bench/other users

Behaviour:
- Reset (rst_a_n low, async): every output = 0. Tick counter = 0. All synchronizer flops = 0. Every FSM = ST_LO. Sample counters = 0.
- Reset deassertion: counter restarts from 0. Reset mid-debounce discards all partial counts.
- Tick generator:
  - tcnt counts 0..TICK_MAX-1 and wraps to 0. Width = $clog2(TICK_MAX).
  - tick_o is registered and high exactly the cycle after tcnt == TICK_MAX-1, i.e. once per TICK_MAX cycles.
- Synchronizer: sync[i] = btn_in[i] delayed 2 clk. The FSM only ever sees sync[i].
- Per-channel FSM: states ST_LO, CHK_HI, ST_HI, CHK_LO. Per-channel scnt has width $clog2(STABLE_TICKS+1). On non-tick cycles, state and scnt hold.
  - ST_LO, tick, sync=1: if STABLE_TICKS==1, go to ST_HI with commit; else go to CHK_HI with scnt=1. Tick with sync=0: stay.
  - CHK_HI, tick, sync=1: scnt+1. When scnt+1 == STABLE_TICKS, go to ST_HI with commit and scnt=0. Tick with sync=0: go to ST_LO, scnt=0 (bounce rejected, no pulse).
  - ST_HI and CHK_LO mirror the above with the polarity inverted.
- Commit: btn_level[i] updates in the same registered edge as the state change. btn_rise/btn_fall[i] is high for exactly that one following cycle.
- Latency from a stable input change to the btn_level change is between 2 + (STABLE_TICKS-1)*TICK_MAX + 1 and 2 + STABLE_TICKS*TICK_MAX + 1 clk.
- Simultaneous commits: channels are independent, so several pulses may assert in the same cycle. No priority between channels.
- Input held high through reset: after STABLE_TICKS ticks, btn_level=1 with a btn_rise pulse.
- A glitch shorter than one tick period that falls between ticks is invisible.

Optional Feature:
DEBOUNCE_AUTOREPEAT_EN
- Defined:
  - Each channel has rcnt, width $clog2(REPEAT_TICKS+1), cleared on entry to ST_HI.
  - In ST_HI, each tick increments rcnt. On reaching REPEAT_TICKS, btn_repeat[i] pulses for 1 cycle and rcnt=0.
  - Leaving ST_HI clears rcnt. No repeat pulse fires in the commit cycle.
- Undefined: btn_repeat is constant 0 and no rcnt registers exist.

Decomposition:
- Package debounce_pkg:
  - state typedef {ST_LO, CHK_HI, ST_HI, CHK_LO}, 2-bit encoded.
  - width constants for tcnt, scnt and rcnt.
- One sub-module, debounce_tick_gen, containing the free-running tick counter and registered tick_o; parameter TICK_MAX.
- The synchronizer and the per-channel FSM live in debounce_ctrl inside a generate loop over N_CH.

Test Plan:
All tests use N_CH=2, TICK_MAX=4, STABLE_TICKS=3 unless stated.
- Reset/tick: hold rst_a_n=0 for 5 cycles, then release -> all outputs 0 during reset; tick_o first high 4 clk after release, then every 4 clk.
- Clean press: btn_in[0] 0->1 and held -> btn_level[0]=1 within 15 clk, btn_rise[0] one cycle wide, btn_in[1] outputs stay 0.
- Bounce rejection: btn_in[0] high for 2 ticks, low at the 3rd tick, then high -> no rise pulse until 3 consecutive high ticks are seen after the low sample.
- Release and simultaneous: both channels high, then both dropped in the same cycle -> btn_fall[0] and btn_fall[1] pulse in the same cycle; btn_level=00.
- Reset mid-check: assert rst_a_n in CHK_HI after 2 good ticks -> level stays 0; after release, 3 fresh ticks are needed.
- With DEBOUNCE_AUTOREPEAT_EN and REPEAT_TICKS=2: hold btn_in[0] high -> btn_repeat[0] pulses every 8 clk after the commit; no repeat pulse after release.
